// File: rtl/ysyx_22051086_trap_ctrl.sv
// ysyx_22051086_trap_ctrl: sequences Zicsr ops, ecall trap entry and mret against the machine CSR file,
// one instruction at a time, returning the old CSR value and a PC redirect.
module ysyx_22051086_trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] pc,
    input  logic        is_csr,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [63:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        src_zero,
    input  logic        rd_nz,
    output logic        rd_wen,
    output logic [63:0] rd_data,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        done,
    output logic [11:0] csr_rnum,
    input  logic [63:0] csr_rdata,
    output logic [11:0] csr_wnum,
    output logic        csr_wen,
    output logic [63:0] csr_wdata,
    output logic [63:0] csr_wmask,
    output logic        ecall
);
    typedef enum logic [2:0] {IDLE, CSR_OP, EC_SAVE, EC_STAT, EC_VEC, MR_STAT, MR_EPC} state_t;
    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [11:0] addr_q;
    logic [63:0] rs1_q;
    logic [4:0]  zimm_q;
    logic        src_zero_q, rd_nz_q;
    logic [63:0] src;
    logic [1:0]  op;
    logic        op_wr;
    // The CSR file takes MEPC straight from the pc bus during the ecall pulse.
    logic        unused_pc;
    assign unused_pc = ^pc;
    assign src   = funct3_q[2] ? {59'b0, zimm_q} : rs1_q;
    assign op    = funct3_q[1:0];
    assign op_wr = op == 2'b01 || (op != 2'b00 && !src_zero_q);
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
        if (in_valid && in_ready) begin
            funct3_q   <= funct3;
            addr_q     <= csr_addr;
            rs1_q      <= rs1_data;
            zimm_q     <= zimm;
            src_zero_q <= src_zero;
            rd_nz_q    <= rd_nz;
        end
    end
    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        rd_wen         = 1'b0;
        rd_data        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        done           = 1'b0;
        csr_rnum       = '0;
        csr_wnum       = '0;
        csr_wen        = 1'b0;
        csr_wdata      = '0;
        csr_wmask      = '0;
        ecall          = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid)
                        state_d = is_ecall ? EC_SAVE : is_mret ? MR_STAT : is_csr ? CSR_OP : IDLE;
                end
                CSR_OP: begin
                    csr_rnum  = addr_q;
                    csr_wen   = op_wr;
                    csr_wnum  = op_wr ? addr_q : '0;
                    csr_wdata = !op_wr ? '0 : op == 2'b01 ? src : op == 2'b10 ? csr_rdata : csr_rdata & ~src;
                    csr_wmask = (op_wr && op == 2'b10) ? src : '0;
                    rd_wen    = rd_nz_q && op != 2'b00;
                    rd_data   = op != 2'b00 ? csr_rdata : '0;
                    done      = 1'b1;
                    state_d   = IDLE;
                end
                EC_SAVE: begin
                    ecall   = 1'b1;
                    state_d = EC_STAT;
                end
                EC_STAT: begin
                    // MPIE <= MIE, MIE <= 0, MPP <= M
                    csr_rnum  = 12'h300;
                    csr_wen   = 1'b1;
                    csr_wnum  = 12'h300;
                    csr_wdata = {csr_rdata[63:13], 2'b11, csr_rdata[10:8], csr_rdata[3],
                                 csr_rdata[6:4], 1'b0, csr_rdata[2:0]};
                    state_d   = EC_VEC;
                end
                EC_VEC: begin
                    csr_rnum       = 12'h305;
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_rdata[63:2], 2'b00};
                    done           = 1'b1;
                    state_d        = IDLE;
                end
                MR_STAT: begin
                    // MIE <= MPIE, MPIE <= 1, MPP <= U
                    csr_rnum  = 12'h300;
                    csr_wen   = 1'b1;
                    csr_wnum  = 12'h300;
                    csr_wdata = {csr_rdata[63:13], 2'b00, csr_rdata[10:8], 1'b1,
                                 csr_rdata[6:4], csr_rdata[7], csr_rdata[2:0]};
                    state_d   = MR_EPC;
                end
                MR_EPC: begin
                    csr_rnum       = 12'h341;
                    redirect_valid = 1'b1;
                    redirect_pc    = csr_rdata;
                    done           = 1'b1;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22051086_trap_ctrl.sv
// tb_ysyx_22051086_trap_ctrl: table vectors, hand-written trap/reset sequences and a random
// instruction stream checked against an arithmetic CSR model.
module tb_ysyx_22051086_trap_ctrl;
    logic        clk = 0, rst = 1, in_valid = 0, in_ready;
    logic [63:0] pc = 0, rs1_data = 0, rd_data, redirect_pc, csr_rdata, csr_wdata, csr_wmask;
    logic        is_csr = 0, is_ecall = 0, is_mret = 0, src_zero = 0, rd_nz = 0;
    logic [2:0]  funct3 = 0;
    logic [11:0] csr_addr = 0, csr_rnum, csr_wnum;
    logic [4:0]  zimm = 0;
    logic        rd_wen, redirect_valid, done, csr_wen, ecall;

    always #5 clk = ~clk;

    ysyx_22051086_trap_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc),
        .is_csr(is_csr), .is_ecall(is_ecall), .is_mret(is_mret), .funct3(funct3),
        .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm), .src_zero(src_zero),
        .rd_nz(rd_nz), .rd_wen(rd_wen), .rd_data(rd_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .done(done), .csr_rnum(csr_rnum), .csr_rdata(csr_rdata),
        .csr_wnum(csr_wnum), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .ecall(ecall)
    );

    // Behavioural CSR file: combinational read, commit wdata|wmask, ecall latches MEPC/MCAUSE.
    logic [63:0] csr_mem [4096];
    logic        pl_en = 0;
    logic [11:0] pl_addr = 0;
    logic [63:0] pl_val = 0;
    assign csr_rdata = csr_mem[csr_rnum];
    always @(posedge clk) begin
        if (pl_en) csr_mem[pl_addr] <= pl_val;
        if (csr_wen) csr_mem[csr_wnum] <= csr_wdata | csr_wmask;
        if (ecall) begin
            csr_mem[12'h341] <= pc;
            csr_mem[12'h342] <= {csr_mem[12'h342][63:4], 4'hB};
        end
    end

    logic [63:0] ref_csr [4096];
    int checks = 0, errors = 0;

    typedef struct {
        int done_cyc; int nwr; int wr_cyc; logic [11:0] wnum; logic [63:0] wval;
        int ec_cyc; int nec; logic rd_wen; logic [63:0] rd_data; int nredir; logic [63:0] rpc;
    } obs_t;

    typedef struct {
        logic [2:0] f3; logic [11:0] a; logic [63:0] r; logic [4:0] z; logic sz, rn;
        logic [63:0] old, fin; logic wen; logic [63:0] wdata, wmask; logic rdw; logic [63:0] rdd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [63:0] v);
        pl_en = 1; pl_addr = a; pl_val = v; ref_csr[a] = v;
        @(negedge clk);
        pl_en = 0;
    endtask

    task automatic set_in(input logic c, e, m, input logic [2:0] f3, input logic [11:0] a,
                          input logic [63:0] r, input logic [4:0] z, input logic sz, rn,
                          input logic [63:0] p);
        is_csr = c; is_ecall = e; is_mret = m; funct3 = f3; csr_addr = a;
        rs1_data = r; zimm = z; src_zero = sz; rd_nz = rn; pc = p;
    endtask

    task automatic offer(input logic c, e, m, input logic [2:0] f3, input logic [11:0] a,
                         input logic [63:0] r, input logic [4:0] z, input logic sz, rn,
                         input logic [63:0] p);
        set_in(c, e, m, f3, a, r, z, sz, rn, p);
        in_valid = 1;
        #1 chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic observe(output obs_t o);
        bit fin;
        fin = 0;
        o = '{default: 0};
        for (int c = 1; c <= 8 && !fin; c++) begin
            #1;
            chk("wen_ecall_exclusive", csr_wen & ecall, 0);
            if (csr_wen) begin o.nwr++; o.wr_cyc = c; o.wnum = csr_wnum; o.wval = csr_wdata | csr_wmask; end
            if (ecall) begin o.nec++; o.ec_cyc = c; end
            if (redirect_valid) begin o.nredir++; o.rpc = redirect_pc; end
            if (done) begin
                o.done_cyc = c; o.rd_wen = rd_wen; o.rd_data = rd_wen ? rd_data : 0; fin = 1;
            end
            @(negedge clk);
        end
        if (!fin) chk("done_timeout", 0, 1);
        #1 chk("ready_after_done", in_ready, 1);
    endtask

    task automatic cmp(input string nm, input obs_t o, input obs_t e);
        chk({nm, "_done_cycle"}, o.done_cyc, e.done_cyc);
        chk({nm, "_writes"}, o.nwr, e.nwr);
        chk({nm, "_write_cycle"}, o.wr_cyc, e.wr_cyc);
        chk({nm, "_wnum"}, o.wnum, e.wnum);
        chk({nm, "_wval"}, o.wval, e.wval);
        chk({nm, "_ecalls"}, o.nec, e.nec);
        chk({nm, "_ecall_cycle"}, o.ec_cyc, e.ec_cyc);
        chk({nm, "_rd_wen"}, o.rd_wen, e.rd_wen);
        chk({nm, "_rd_data"}, o.rd_data, e.rd_data);
        chk({nm, "_redirects"}, o.nredir, e.nredir);
        chk({nm, "_redirect_pc"}, o.rpc, e.rpc);
    endtask

    function automatic logic [63:0] ec_stat(input logic [63:0] old);
        return (old & ~64'h88) | ((old & 64'h8) << 4) | 64'h1800;
    endfunction

    function automatic logic [63:0] mret_stat(input logic [63:0] old);
        return (old & ~64'h1888) | ((old >> 4) & 64'h8) | 64'h80;
    endfunction

    function automatic obs_t model(input logic c, e, m, input logic [2:0] f3, input logic [11:0] a,
                                   input logic [63:0] r, input logic [4:0] z, input logic sz, rn,
                                   input logic [63:0] p);
        obs_t x;
        logic [63:0] old, src, nv;
        x = '{default: 0};
        if (e) begin
            x.done_cyc = 3; x.nwr = 1; x.wr_cyc = 2; x.wnum = 12'h300;
            x.wval = ec_stat(ref_csr[12'h300]); x.ec_cyc = 1; x.nec = 1;
            x.nredir = 1; x.rpc = ref_csr[12'h305] & ~64'h3;
            ref_csr[12'h300] = x.wval;
            ref_csr[12'h341] = p;
            ref_csr[12'h342] = (ref_csr[12'h342] & ~64'hF) | 64'hB;
        end else if (m) begin
            x.done_cyc = 2; x.nwr = 1; x.wr_cyc = 1; x.wnum = 12'h300;
            x.wval = mret_stat(ref_csr[12'h300]);
            x.nredir = 1; x.rpc = ref_csr[12'h341];
            ref_csr[12'h300] = x.wval;
        end else if (c) begin
            x.done_cyc = 1;
            old = ref_csr[a];
            src = f3[2] ? 64'(z) : r;
            if (f3[1:0] != 2'b00) begin
                x.rd_wen = rn; x.rd_data = rn ? old : 0;
                if (f3[1:0] == 2'b01 || !sz) begin
                    nv = f3[1:0] == 2'b01 ? src : f3[1:0] == 2'b10 ? (old | src) : (old & ~src);
                    x.nwr = 1; x.wr_cyc = 1; x.wnum = a; x.wval = nv;
                    ref_csr[a] = nv;
                end
            end
        end
        return x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[8];
        obs_t o, e;
        logic [11:0] addrs[5];
        tv[0] = '{3'b001, 12'h305, 64'h80000103, 5'd0, 1'b0, 1'b1, 64'h0, 64'h80000103,
                  1'b1, 64'h80000103, 64'h0, 1'b1, 64'h0};
        tv[1] = '{3'b110, 12'h300, 64'h0, 5'd8, 1'b0, 1'b1, 64'ha00001800, 64'ha00001808,
                  1'b1, 64'ha00001800, 64'h8, 1'b1, 64'ha00001800};
        tv[2] = '{3'b011, 12'h300, 64'h0, 5'd0, 1'b1, 1'b1, 64'ha00001808, 64'ha00001808,
                  1'b0, 64'h0, 64'h0, 1'b1, 64'ha00001808};
        tv[3] = '{3'b000, 12'h340, 64'hdead, 5'd0, 1'b0, 1'b1, 64'h1234, 64'h1234,
                  1'b0, 64'h0, 64'h0, 1'b0, 64'h0};
        tv[4] = '{3'b100, 12'h340, 64'h0, 5'd3, 1'b0, 1'b1, 64'h1234, 64'h1234,
                  1'b0, 64'h0, 64'h0, 1'b0, 64'h0};
        tv[5] = '{3'b111, 12'h340, 64'h0, 5'd5, 1'b0, 1'b0, 64'hff, 64'hfa,
                  1'b1, 64'hfa, 64'h0, 1'b0, 64'hff};
        tv[6] = '{3'b101, 12'h340, 64'h0, 5'd0, 1'b1, 1'b1, 64'h55, 64'h0,
                  1'b1, 64'h0, 64'h0, 1'b1, 64'h55};
        tv[7] = '{3'b010, 12'h340, 64'hf0, 5'd0, 1'b0, 1'b1, 64'h0f, 64'hff,
                  1'b1, 64'h0f, 64'hf0, 1'b1, 64'h0f};
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};

        // reset: everything quiet, ready only once rst drops
        in_valid = 1; is_csr = 1; funct3 = 3'b001;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_csr_wen", csr_wen, 0);
        chk("rst_redirect", redirect_valid, 0);
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        #1 chk("ready_after_rst", in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            preload(tv[i].a, tv[i].old);
            offer(1, 0, 0, tv[i].f3, tv[i].a, tv[i].r, tv[i].z, tv[i].sz, tv[i].rn, 0);
            #1;
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_csr_wen", i), csr_wen, tv[i].wen);
            chk($sformatf("v%0d_wnum", i), csr_wnum, tv[i].wen ? 64'(tv[i].a) : 64'h0);
            chk($sformatf("v%0d_wdata", i), csr_wdata, tv[i].wdata);
            chk($sformatf("v%0d_wmask", i), csr_wmask, tv[i].wmask);
            chk($sformatf("v%0d_rd_wen", i), rd_wen, tv[i].rdw);
            chk($sformatf("v%0d_rd_data", i), rd_data, tv[i].rdd);
            chk($sformatf("v%0d_busy", i), in_ready, 0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_ready", i), in_ready, 1);
            chk($sformatf("v%0d_done_low", i), done, 0);
            chk($sformatf("v%0d_readback", i), csr_mem[tv[i].a], tv[i].fin);
        end

        // ecall then mret
        preload(12'h300, 64'ha00001808);
        preload(12'h305, 64'h80000103);
        preload(12'h342, 64'h0);
        offer(0, 1, 0, 0, 0, 0, 0, 0, 0, 64'h80000040);
        observe(o);
        e = '{3, 1, 2, 12'h300, 64'ha00001880, 1, 1, 1'b0, 64'h0, 1, 64'h80000100};
        cmp("ecall", o, e);
        chk("ecall_mepc", csr_mem[12'h341], 64'h80000040);
        chk("ecall_mcause", csr_mem[12'h342][3:0], 4'hB);
        offer(0, 0, 1, 0, 0, 0, 0, 0, 0, 64'h80000044);
        observe(o);
        e = '{2, 1, 1, 12'h300, 64'ha00000088, 0, 0, 1'b0, 64'h0, 1, 64'h80000040};
        cmp("mret", o, e);

        // reset while in EC_STAT abandons the sequence
        offer(0, 1, 0, 0, 0, 0, 0, 0, 0, 64'h1000);
        #1 chk("rstseq_ecall", ecall, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rstseq_wen", csr_wen, 0);
        chk("rstseq_redirect", redirect_valid, 0);
        chk("rstseq_ready", in_ready, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rstseq_ready_back", in_ready, 1);
        chk("rstseq_no_redirect", redirect_valid, 0);
        chk("rstseq_no_done", done, 0);
        chk("rstseq_mstatus", csr_mem[12'h300], 64'ha00000088);
        @(negedge clk);

        // offers while busy are ignored
        preload(12'h340, 64'h77);
        offer(0, 0, 1, 0, 0, 0, 0, 0, 0, 64'h2000);
        set_in(1, 0, 0, 3'b001, 12'h340, 64'hbad, 0, 0, 1, 64'h2000);
        in_valid = 1;
        #1 chk("busy_ready", in_ready, 0);
        @(negedge clk);
        #1;
        chk("busy_done", done, 1);
        chk("busy_redirect_pc", redirect_pc, 64'h1000);
        in_valid = 0;
        @(negedge clk);
        #1;
        chk("busy_ignored_done", done, 0);
        chk("busy_ignored_ready", in_ready, 1);
        chk("busy_ignored_wen", csr_wen, 0);
        chk("busy_ignored_mem", csr_mem[12'h340], 64'h77);

        // offer with no class bit
        set_in(0, 0, 0, 3'b001, 12'h340, 64'h5, 0, 0, 1, 0);
        in_valid = 1;
        #1 chk("noclass_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("noclass_done", done, 0);
        chk("noclass_idle", in_ready, 1);
        chk("noclass_wen", csr_wen, 0);
        chk("noclass_ecall", ecall, 0);
        @(negedge clk);

        // random stream against the model, issued back to back
        foreach (addrs[k]) preload(addrs[k], {$urandom, $urandom});
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  cls, f3;
            logic [11:0] a;
            logic [63:0] r, p;
            logic [4:0]  z;
            logic        sz, rn;
            cls = 3'($urandom_range(1, 7));
            f3  = 3'($urandom);
            a   = addrs[$urandom_range(0, 4)];
            r   = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            z   = 5'($urandom);
            sz  = f3[2] ? (z == 0) : (r == 0);
            rn  = 1'($urandom);
            p   = {$urandom, $urandom};
            if (cls == 3'b100 && $urandom_range(0, 2) != 0) cls = 3'b100;
            e = model(cls[2], cls[0], cls[1], f3, a, r, z, sz, rn, p);
            offer(cls[2], cls[0], cls[1], f3, a, r, z, sz, rn, p);
            observe(o);
            cmp($sformatf("rnd%0d", n), o, e);
        end
        foreach (addrs[k]) chk($sformatf("final_csr_%h", addrs[k]), csr_mem[addrs[k]], ref_csr[addrs[k]]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
